// File: rtl/sqvl_pkg.sv
// rtl/sqvl_pkg.sv - shared defaults and code type for the square-wave voltage path
package sqvl_pkg;

  localparam int SQVL_WIDTH_DEF = 12;
  localparam int SQVL_DEPTH_DEF = 2;
  localparam int SQVL_DEPTH_MAX = 8;

  typedef logic [SQVL_WIDTH_DEF-1:0] sqvl_code_t;

endpackage

// File: rtl/sqvl_delay_line.sv
// rtl/sqvl_delay_line.sv - free-running {data, valid} shift pipeline, no stall
module sqvl_delay_line
  import sqvl_pkg::*;
#(
  parameter int WIDTH = SQVL_WIDTH_DEF,
  parameter int DEPTH = SQVL_DEPTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] tail_data,
  output logic             tail_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= din;
      valid_q[0] <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign tail_data  = data_q[DEPTH-1];
  assign tail_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/sqvl_vpath_slew.sv
// rtl/sqvl_vpath_slew.sv - delayed, enable-gated DAC code register with optional slew limiting
module sqvl_vpath_slew
  import sqvl_pkg::*;
#(
  parameter int               WIDTH     = SQVL_WIDTH_DEF,
  parameter int               DEPTH     = SQVL_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_Valid,
  input  logic             EN,
  input  logic             Slew_En,
  input  logic [WIDTH-1:0] Slew_Step,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_Valid,
  output logic             Busy
);

  logic [WIDTH-1:0] tail_data;
  logic             tail_valid;
  logic [WIDTH-1:0] target;
  logic             pending;

  logic             capture;
  logic [WIDTH-1:0] next_target;
  logic [WIDTH-1:0] next_dout;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;
  logic             want_pending;

  sqvl_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_delay (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .din        (Din),
    .din_valid  (Din_Valid),
    .tail_data  (tail_data),
    .tail_valid (tail_valid)
  );

  // Steps are taken toward the target that will be held after this edge, so a
  // retarget redirects the ramp immediately from the current Dout.
  always_comb begin
    capture      = EN & tail_valid;
    next_target  = capture ? tail_data : target;
    want_pending = capture | pending;
    diff         = {1'b0, next_target} - {1'b0, Dout};
    mag          = diff[WIDTH] ? (~diff + 1'b1) : diff;
    next_dout    = next_target;
    if (Slew_En && (mag > {1'b0, Slew_Step})) begin
      next_dout = diff[WIDTH] ? (Dout - Slew_Step) : (Dout + Slew_Step);
    end
  end

  // pending marks a loaded target not yet reached, so each load pulses once.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      target     <= RESET_VAL;
      Dout       <= RESET_VAL;
      pending    <= 1'b0;
      Dout_Valid <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      target     <= next_target;
      Dout       <= next_dout;
      Busy       <= (next_dout != next_target);
      Dout_Valid <= want_pending && (next_dout == next_target);
      pending    <= want_pending && (next_dout != next_target);
    end
  end

endmodule

// File: tb/tb_sqvl_vpath_slew.sv
// tb/tb_sqvl_vpath_slew.sv - directed self-checking bench for sqvl_vpath_slew
module tb_sqvl_vpath_slew;
  import sqvl_pkg::*;

  logic       Clock;
  logic       Reset_n;
  sqvl_code_t Din;
  logic       Din_Valid;
  logic       EN;
  logic       Slew_En;
  sqvl_code_t Slew_Step;
  sqvl_code_t Dout;
  logic       Dout_Valid;
  logic       Busy;

  int n_assert = 0;
  int n_fail   = 0;

  sqvl_vpath_slew #(.WIDTH(12), .DEPTH(2), .RESET_VAL(12'h000)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Din        (Din),
    .Din_Valid  (Din_Valid),
    .EN         (EN),
    .Slew_En    (Slew_En),
    .Slew_Step  (Slew_Step),
    .Dout       (Dout),
    .Dout_Valid (Dout_Valid),
    .Busy       (Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] d, input logic dv, input logic b);
    chk({tag, ".dout"}, {4'h0, Dout}, {4'h0, d});
    chk({tag, ".valid"}, {15'h0, Dout_Valid}, {15'h0, dv});
    chk({tag, ".busy"}, {15'h0, Busy}, {15'h0, b});
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present one valid code for one edge, then let it reach the tail stage.
  task automatic load(input logic [11:0] code);
    Din       = code;
    Din_Valid = 1'b1;
    step();
    Din       = '0;
    Din_Valid = 1'b0;
    step();
  endtask

  initial begin
    Reset_n   = 1'b0;
    Din       = '0;
    Din_Valid = 1'b0;
    EN        = 1'b0;
    Slew_En   = 1'b0;
    Slew_Step = '0;
    #2;
    chk_all("reset", 12'h000, 1'b0, 1'b0);
    repeat (2) step();
    Reset_n = 1'b1;

    // EN gating: tail value dropped when EN=0 at the capture edge
    load(12'h123);
    chk_all("gate_e2", 12'h000, 1'b0, 1'b0);
    step();
    chk_all("gate_e3", 12'h000, 1'b0, 1'b0);
    step();
    chk_all("gate_e4", 12'h000, 1'b0, 1'b0);

    // Direct mode latency: three edges from presentation to Dout
    EN = 1'b1;
    load(12'h5A5);
    chk_all("lat_e2", 12'h000, 1'b0, 1'b0);
    step();
    chk_all("lat_e3", 12'h5A5, 1'b1, 1'b0);
    step();
    chk_all("lat_e4", 12'h5A5, 1'b0, 1'b0);

    load(12'h000);
    step();
    chk_all("zero_e3", 12'h000, 1'b1, 1'b0);
    step();
    chk_all("zero_e4", 12'h000, 1'b0, 1'b0);

    // Slew up 0x000 -> 0x350 in steps of 0x100
    Slew_En   = 1'b1;
    Slew_Step = 12'h100;
    load(12'h350);
    step();
    chk_all("up_1", 12'h100, 1'b0, 1'b1);
    step();
    chk_all("up_2", 12'h200, 1'b0, 1'b1);
    step();
    chk_all("up_3", 12'h300, 1'b0, 1'b1);
    step();
    chk_all("up_4", 12'h350, 1'b1, 1'b0);
    step();
    chk_all("up_5", 12'h350, 1'b0, 1'b0);

    // Slew down with clamp: 0x010 -> 0x000 without wrapping
    Slew_En = 1'b0;
    load(12'h010);
    step();
    chk_all("dn_set", 12'h010, 1'b1, 1'b0);
    Slew_En = 1'b1;
    load(12'h000);
    step();
    chk_all("dn_clamp", 12'h000, 1'b1, 1'b0);
    step();
    chk_all("dn_after", 12'h000, 1'b0, 1'b0);

    // Retarget mid-ramp: 0x800 abandoned at 0x300 for 0x100
    load(12'h800);
    step();
    chk_all("rt_1", 12'h100, 1'b0, 1'b1);
    Din       = 12'h100;
    Din_Valid = 1'b1;
    step();
    chk_all("rt_2", 12'h200, 1'b0, 1'b1);
    Din       = '0;
    Din_Valid = 1'b0;
    step();
    chk_all("rt_3", 12'h300, 1'b0, 1'b1);
    step();
    chk_all("rt_4", 12'h200, 1'b0, 1'b1);
    step();
    chk_all("rt_5", 12'h100, 1'b1, 1'b0);
    step();
    chk_all("rt_6", 12'h100, 1'b0, 1'b0);

    // Slew_Step=0 holds; Slew_En falling finishes the move in one edge
    Slew_Step = 12'h000;
    load(12'h180);
    step();
    chk_all("hold_1", 12'h100, 1'b0, 1'b1);
    step();
    chk_all("hold_2", 12'h100, 1'b0, 1'b1);
    Slew_En = 1'b0;
    step();
    chk_all("fall_1", 12'h180, 1'b1, 1'b0);
    step();
    chk_all("fall_2", 12'h180, 1'b0, 1'b0);

    // Async reset mid-ramp with a valid code still in the pipeline
    Slew_En   = 1'b1;
    Slew_Step = 12'h100;
    load(12'hF00);
    step();
    chk_all("rst_ramp1", 12'h280, 1'b0, 1'b1);
    Din       = 12'hABC;
    Din_Valid = 1'b1;
    step();
    chk_all("rst_ramp2", 12'h380, 1'b0, 1'b1);
    Din       = '0;
    Din_Valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("rst_async", 12'h000, 1'b0, 1'b0);
    #1;
    Reset_n = 1'b1;
    step();
    chk_all("rst_post1", 12'h000, 1'b0, 1'b0);
    step();
    chk_all("rst_post2", 12'h000, 1'b0, 1'b0);
    step();
    chk_all("rst_post3", 12'h000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
